vga_sync_gen: RTL

Generates VGA 640x480@60 timing for the pong display. Produces the pixel enable, pixel coordinates, blanking flag and sync pulses that the pixel generator consumes. Sits between the board clock and the pixel generator; its hsync/vsync go straight to the VGA connector pins. Sync outputs are delayed one pixel so they line up with the pixel generator's one-pixel-late RGB latch.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_mod_counter.sv | 41 ++++
 rtl/vga_sync_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA 640x480@60 timing constants shared by the sync generator
package vga_timing_pkg;

    // Coordinate width: wide enough for H_TOTAL-1 = 799 and V_TOTAL-1 = 524
    localparam int COORD_W = 10;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // 1 = sync pulses drive 0 while active (standard 640x480 polarity)
    localparam bit VGA_SYNC_ACTIVE_LOW = 1'b1;

    // Register width for a modulo-n count; never below 1 so n=1 still elaborates
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// rtl/vga_mod_counter.sv - modulo-N counter with enable and a combinational wrap flag
module vga_mod_counter
    import vga_timing_pkg::*;
#(
    parameter int N = 2,
    parameter int W = cnt_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // wrap marks the enabled step that returns the count to zero
    assign wrap  = en && (count_q == LAST);
    assign count = count_q;

    // Next count: hold when disabled, step or wrap when enabled
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA timing generator; VGA_FRAME_CNT_EN adds the frame_cnt output
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV         = 2,
    parameter int H_DISPLAY       = VGA_H_DISPLAY,
    parameter int H_FP            = VGA_H_FP,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BP            = VGA_H_BP,
    parameter int V_DISPLAY       = VGA_V_DISPLAY,
    parameter int V_FP            = VGA_V_FP,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BP            = VGA_V_BP,
    parameter bit SYNC_ACTIVE_LOW = VGA_SYNC_ACTIVE_LOW
) (
    input  logic               clk,
    input  logic               rst,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = cnt_width(CLK_DIV);

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_DISP_C = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_DISP_C = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_DISPLAY + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_DISPLAY + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_DISPLAY + V_FP + V_SYNC - 1);
    localparam logic               SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic               SYNC_OFF = ~SYNC_ON;

    // run_q holds the divider still for the first clk after reset release so
    // p_tick never appears during reset (matters for CLK_DIV=1) and the first
    // tick lands exactly CLK_DIV clks after release for every divide ratio.
    logic               run_q, run_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic [COORD_W-1:0] h_cnt, v_cnt;
    logic               h_wrap, v_wrap;
    logic               h_in_sync, v_in_sync;

    assign p_tick    = run_q && (div_q == DIV_LAST);
    assign h_in_sync = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign v_in_sync = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

    vga_mod_counter #(.N(H_TOTAL), .W(COORD_W)) u_h_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (p_tick),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    // h_wrap already includes p_tick, so v steps on the same tick as the line wrap
    vga_mod_counter #(.N(V_TOTAL), .W(COORD_W)) u_v_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    assign pixel_x     = h_cnt;
    assign pixel_y     = v_cnt;
    assign video_on    = (h_cnt < H_DISP_C) && (v_cnt < V_DISP_C);
    assign frame_start = v_wrap;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;

    // Divider step and sync capture from the pre-increment counters (one pixel late)
    always_comb begin
        run_d   = 1'b1;
        div_d   = div_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (run_q) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
        if (p_tick) begin
            hsync_d = h_in_sync ? SYNC_ON : SYNC_OFF;
            vsync_d = v_in_sync ? SYNC_ON : SYNC_OFF;
        end
    end

    // Timing registers; syncs clear to their inactive level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q   <= 1'b0;
            div_q   <= '0;
            hsync_q <= SYNC_OFF;
            vsync_q <= SYNC_OFF;
        end else begin
            run_q   <= run_d;
            div_q   <= div_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frames completed; wraps naturally at 16 bits
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Frame counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
